// File: rtl/ahb_pkg.sv
// Shared AHB3-Lite encodings plus the interface-parity helpers.
// The RAM checker uses the same parity/checksum functions, so keep them pure.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // One buffered response
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chkerr;
    } ahb_rsp_t;

    // Address/control parity: bits 0..3 fold haddr nibble-wise,
    // bit 4 covers control, bit 5 covers htrans.
    function automatic logic [5:0] ahb_parity(
        input logic [31:0] haddr,
        input logic [1:0]  htrans,
        input logic        hwrite,
        input logic [2:0]  hsize,
        input logic [2:0]  hburst,
        input logic [3:0]  hprot,
        input logic        hmastlock
    );
        logic [5:0] p;
        p = '0;
        for (int j = 0; j < 8; j++) p[3:0] = p[3:0] ^ haddr[4*j +: 4];
        p[4] = ^hsize ^ ^hburst ^ ^hprot ^ hwrite ^ hmastlock;
        p[5] = ^htrans;
        return p;
    endfunction

    // Data checksum: bit k is the XOR of every data bit whose index is k mod 7
    function automatic logic [6:0] ahb_checksum(input logic [31:0] d);
        logic [6:0] c;
        c = '0;
        for (int k = 0; k < 7; k++)
            for (int i = k; i < 32; i += 7) c[k] = c[k] ^ d[i];
        return c;
    endfunction

endpackage

// File: rtl/ahb_rsp_fifo.sv
// Small synchronous response FIFO with an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module ahb_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             s_clk_i,
    input  logic             s_resetn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        do_push, do_pop;

    assign empty_o    = (count_o == '0);
    assign do_push    = push_i & (count_o != CW'(DEPTH));
    assign do_pop     = pop_i & ~empty_o;
    assign pop_data_o = mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by the count
    always_ff @(posedge s_clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

    // Pointers and occupancy
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-port AHB3-Lite master: valid/ready requests in, buffered responses out.
// Address phase is combinational from the request; a credit check guarantees a
// FIFO slot for every transfer in flight, so the bus never stalls on the consumer.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int RSP_DEPTH = 2,
    parameter bit IFP       = 1'b0
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_chkerr_o,
    output logic [31:0] m_haddr_o,
    output logic [1:0]  m_htrans_o,
    output logic        m_hwrite_o,
    output logic [2:0]  m_hsize_o,
    output logic [2:0]  m_hburst_o,
    output logic [3:0]  m_hprot_o,
    output logic        m_hmastlock_o,
    output logic [31:0] m_hwdata_o,
    output logic [5:0]  m_hparity_o,
    output logic [6:0]  m_hwchecksum_o,
    input  logic [31:0] m_hrdata_i,
    input  logic        m_hready_i,
    input  logic        m_hresp_i,
    input  logic [6:0]  m_hrchecksum_i
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(RSP_DEPTH);

    logic          cancel, can_issue, accept, complete;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    logic          fifo_empty;
    ahb_rsp_t      push_entry, pop_entry;

    // Data-phase register
    logic          d_valid;
    logic          d_write;
    logic [1:0]    d_size;
    logic [1:0]    d_addr_lo;
    logic [31:0]   d_wdata;

    logic [31:0]   rd_shift, rd_align;

    // First ERROR cycle blocks issue; a same-cycle pop earns no credit
    assign cancel      = m_hresp_i & ~m_hready_i;
    assign inflight    = {1'b0, fifo_count} + {{CW{1'b0}}, d_valid};
    assign can_issue   = ~cancel & (inflight < DEPTH_L);
    assign req_ready_o = can_issue & m_hready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign complete    = d_valid & m_hready_i;

    assign m_htrans_o    = (req_valid_i & can_issue) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign m_haddr_o     = req_addr_i;
    assign m_hwrite_o    = req_write_i;
    assign m_hsize_o     = {1'b0, req_size_i};
    assign m_hburst_o    = HBURST_SINGLE;
    assign m_hprot_o     = HPROT_DEFAULT;
    assign m_hmastlock_o = 1'b0;
    assign m_hwdata_o    = d_wdata;

    assign m_hparity_o    = IFP ? ahb_parity(m_haddr_o, m_htrans_o, m_hwrite_o, m_hsize_o,
                                             m_hburst_o, m_hprot_o, m_hmastlock_o) : 6'd0;
    assign m_hwchecksum_o = IFP ? ahb_checksum(m_hwdata_o) : 7'd0;

    // Capture the transfer attributes needed in the data phase
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            d_size    <= 2'd0;
            d_addr_lo <= 2'd0;
            d_wdata   <= '0;
        end else if (accept) begin
            d_valid   <= 1'b1;
            d_write   <= req_write_i;
            d_size    <= req_size_i;
            d_addr_lo <= req_addr_i[1:0];
            d_wdata   <= req_wdata_i;
        end else if (m_hready_i) begin
            d_valid   <= 1'b0;
        end
    end

    // Move the addressed lane down to bit 0 and clear bytes beyond the size
    assign rd_shift = m_hrdata_i >> {d_addr_lo, 3'b000};
    always_comb begin
        rd_align = rd_shift;
        case (d_size)
            2'd0:    rd_align = {24'd0, rd_shift[7:0]};
            2'd1:    rd_align = {16'd0, rd_shift[15:0]};
            default: rd_align = rd_shift;
        endcase
    end

    // Response for the completing data phase
    always_comb begin
        push_entry.err    = m_hresp_i;
        push_entry.rdata  = (d_write | m_hresp_i) ? 32'd0 : rd_align;
        push_entry.chkerr = IFP & ~d_write & ~m_hresp_i &
                            (ahb_checksum(m_hrdata_i) != m_hrchecksum_i);
    end

    ahb_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(ahb_rsp_t))
    ) u_rsp_fifo (
        .s_clk_i     (s_clk_i),
        .s_resetn_i  (s_resetn_i),
        .push_i      (complete),
        .push_data_i (push_entry),
        .pop_i       (rsp_valid_o & rsp_ready_i),
        .pop_data_o  (pop_entry),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign rsp_valid_o  = ~fifo_empty;
    assign rsp_rdata_o  = pop_entry.rdata;
    assign rsp_err_o    = pop_entry.err;
    assign rsp_chkerr_o = pop_entry.chkerr;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Scoreboard bench for ahb_lite_master: directed requests push expected
// responses; a monitor pops and compares whenever a response is consumed.
// A small slave model with memory answers the bus and can inject ERROR
// responses or corrupt the read checksum on a chosen transfer.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_chkerr;
    logic [31:0] rsp_rdata;
    logic [31:0] m_haddr, m_hwdata, m_hrdata;
    logic [1:0]  m_htrans;
    logic        m_hwrite, m_hmastlock, m_hready, m_hresp;
    logic [2:0]  m_hsize, m_hburst;
    logic [3:0]  m_hprot;
    logic [5:0]  m_hparity;
    logic [6:0]  m_hwchecksum, m_hrchecksum;

    // IFP=0 twin, fed the same inputs
    logic        req_ready_0, rsp_valid_0, rsp_err_0, rsp_chkerr_0, hwrite_0, hmastlock_0;
    logic [31:0] rsp_rdata_0, haddr_0, hwdata_0;
    logic [1:0]  htrans_0;
    logic [2:0]  hsize_0, hburst_0;
    logic [3:0]  hprot_0;
    logic [5:0]  hparity_0;
    logic [6:0]  hwchecksum_0;

    ahb_lite_master #(.RSP_DEPTH(2), .IFP(1'b1)) u_dut (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_size_i(req_size), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_chkerr_o(rsp_chkerr),
        .m_haddr_o(m_haddr), .m_htrans_o(m_htrans), .m_hwrite_o(m_hwrite),
        .m_hsize_o(m_hsize), .m_hburst_o(m_hburst), .m_hprot_o(m_hprot),
        .m_hmastlock_o(m_hmastlock), .m_hwdata_o(m_hwdata), .m_hparity_o(m_hparity),
        .m_hwchecksum_o(m_hwchecksum), .m_hrdata_i(m_hrdata), .m_hready_i(m_hready),
        .m_hresp_i(m_hresp), .m_hrchecksum_i(m_hrchecksum)
    );

    ahb_lite_master #(.RSP_DEPTH(2), .IFP(1'b0)) u_dut0 (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_0), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_size_i(req_size), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_0), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_0),
        .rsp_err_o(rsp_err_0), .rsp_chkerr_o(rsp_chkerr_0),
        .m_haddr_o(haddr_0), .m_htrans_o(htrans_0), .m_hwrite_o(hwrite_0),
        .m_hsize_o(hsize_0), .m_hburst_o(hburst_0), .m_hprot_o(hprot_0),
        .m_hmastlock_o(hmastlock_0), .m_hwdata_o(hwdata_0), .m_hparity_o(hparity_0),
        .m_hwchecksum_o(hwchecksum_0), .m_hrdata_i(m_hrdata), .m_hready_i(m_hready),
        .m_hresp_i(m_hresp), .m_hrchecksum_i(m_hrchecksum)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] tb_cks(input logic [31:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c[i % 7] = c[i % 7] ^ d[i];
        return c;
    endfunction

    // Parity of a NONSEQ address phase with hburst=0, hprot=0011, hmastlock=0
    function automatic logic [5:0] tb_par(input logic [31:0] a, input logic w, input logic [1:0] sz);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) p[i % 4] = p[i % 4] ^ a[i];
        p[4] = sz[1] ^ sz[0] ^ w;
        p[5] = 1'b1;
        return p;
    endfunction

    // ---------------- slave model ----------------
    logic [31:0] mem [0:63];
    logic [1:0]  es;          // 0 normal, 1 first ERROR cycle, 2 second ERROR cycle
    logic        dp_valid, dp_write;
    logic [31:0] dp_addr;
    int          xfer_cnt, dp_idx;
    int          err_on = -1;
    int          bad_on = -1;

    assign m_hready     = (es != 2'd1);
    assign m_hresp      = (es != 2'd0);
    assign m_hrdata     = mem[dp_addr[7:2]];
    assign m_hrchecksum = tb_cks(m_hrdata) ^ ((dp_idx == bad_on) ? 7'h01 : 7'h00);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            es <= 2'd0; dp_valid <= 1'b0; dp_write <= 1'b0; dp_addr <= '0;
            xfer_cnt <= 0; dp_idx <= 0;
        end else if (es == 2'd1) begin
            es <= 2'd2;
        end else if (m_hready) begin
            if (dp_valid && dp_write && es == 2'd0) mem[dp_addr[7:2]] <= m_hwdata;
            dp_valid <= (m_htrans == 2'b10);
            dp_addr  <= m_haddr;
            dp_write <= m_hwrite;
            if (m_htrans == 2'b10) begin
                xfer_cnt <= xfer_cnt + 1;
                dp_idx   <= xfer_cnt + 1;
                es       <= (xfer_cnt + 1 == err_on) ? 2'd1 : 2'd0;
            end else begin
                es <= 2'd0;
            end
        end
    end

    // Bus-side checks during ERROR cycle 1 and write data phases
    initial forever begin
        @(negedge clk);
        if (rst_n && es == 2'd1) begin
            chk("err1_htrans_idle", m_htrans, 2'b00);
            chk("err1_req_ready", req_ready, 1'b0);
        end
        if (rst_n && dp_valid && dp_write && es == 2'd0) begin
            chk("hwchecksum", m_hwchecksum, tb_cks(m_hwdata));
            chk("ifp0_hwchecksum", hwchecksum_0, 7'd0);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chkerr;
    } exp_t;
    exp_t exp_q[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp", {rsp_rdata, rsp_err, rsp_chkerr}, e);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] r, input logic ee, input logic ec);
        exp_t e;
        e.rdata = r; e.err = ee; e.chkerr = ec;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Offer one request until accepted; hp < 0 selects the computed parity
    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input logic ec, input int hp, output int acc);
        logic [5:0] ep;
        ep = (hp < 0) ? tb_par(a, w, sz) : hp[5:0];
        req_valid = 1'b1; req_addr = a; req_write = w; req_size = sz; req_wdata = wd;
        acc = -1;
        for (int t = 0; t < 40 && acc < 0; t++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                chk("ap_htrans", m_htrans, 2'b10);
                chk("ap_haddr", m_haddr, a);
                chk("ap_hsize", m_hsize, {1'b0, sz});
                chk("ap_hparity", m_hparity, ep);
                chk("ifp0_hparity", hparity_0, 6'd0);
                push_exp(er, ee, ec);
            end
            @(posedge clk); #1;
        end
        if (acc < 0) chk("issue_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    logic [31:0] bp_addr [3] = '{32'h10, 32'h20, 32'h23};
    logic [1:0]  bp_size [3] = '{2'd2, 2'd2, 2'd0};
    logic [31:0] bp_exp  [3] = '{32'hDEADBEEF, 32'hA1B2C3D4, 32'h000000A1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, k;
        req_valid = 0; req_addr = 0; req_write = 0; req_size = 2'd2; req_wdata = 0;
        rsp_ready = 1;

        // reset state
        @(negedge clk);
        chk("rst_htrans", m_htrans, 2'b00);
        chk("rst_haddr", m_haddr, 32'd0);
        chk("rst_hwrite", m_hwrite, 1'b0);
        chk("rst_hsize", m_hsize, 3'd2);
        chk("rst_hwdata", m_hwdata, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("const_bus", {m_hburst, m_hprot, m_hmastlock}, {3'd0, 4'b0011, 1'b0});
        chk("rst_hparity", m_hparity, 6'h10);
        chk("rst_hwchecksum", m_hwchecksum, 7'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        // write then read back-to-back
        issue(32'h10, 1, 2, 32'hDEADBEEF, 32'h0, 0, 0, -1, a1);
        issue(32'h10, 0, 2, 32'h0, 32'hDEADBEEF, 0, 0, -1, a2);
        chk("b2b_consecutive", a2, a1 + 1);
        idle(3);

        // sub-word alignment
        issue(32'h20, 1, 2, 32'hA1B2C3D4, 32'h0, 0, 0, -1, a1);
        issue(32'h23, 0, 0, 32'h0, 32'h000000A1, 0, 0, -1, a1);
        issue(32'h22, 0, 1, 32'h0, 32'h0000A1B2, 0, 0, -1, a1);
        issue(32'h21, 0, 0, 32'h0, 32'h000000C3, 0, 0, -1, a1);
        idle(4);

        // read latency: push N+1, rsp_valid in N+2
        issue(32'h20, 0, 2, 32'h0, 32'hA1B2C3D4, 0, 0, -1, a1);
        @(negedge clk); chk("lat_n1_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_n2_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        idle(3);

        // ERROR on the first of two reads; second waits and completes normally
        err_on = xfer_cnt + 1;
        issue(32'h10, 0, 2, 32'h0, 32'h0, 1, 0, -1, a1);
        issue(32'h20, 0, 2, 32'h0, 32'hA1B2C3D4, 0, 0, -1, a2);
        chk("err_reissue_gap", a2, a1 + 2);
        err_on = -1;
        idle(4);

        // back-pressure: only two transfers may be outstanding
        rsp_ready = 0; k = 0;
        req_valid = 1; req_write = 0; req_wdata = 0;
        req_addr = bp_addr[0]; req_size = bp_size[0];
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (req_ready) begin push_exp(bp_exp[k], 0, 0); k++; end
            else if (k == 2) chk("bp_no_bus", m_htrans, 2'b00);
            @(posedge clk); #1;
            if (k < 3) begin req_addr = bp_addr[k]; req_size = bp_size[k]; end
        end
        chk("bp_accepts", k, 2);
        rsp_ready = 1;
        @(negedge clk); chk("bp_pop_no_credit", req_ready, 1'b0);
        @(posedge clk); #1;
        for (int t = 0; t < 10 && k < 3; t++) begin
            @(negedge clk);
            if (req_ready) begin push_exp(bp_exp[k], 0, 0); k++; end
            @(posedge clk); #1;
        end
        chk("bp_third", k, 3);
        req_valid = 0;
        idle(5);

        // parity by hand at 0xF0, then a corrupted read checksum
        bad_on = xfer_cnt + 2;
        issue(32'hF0, 1, 2, 32'h0F0F0F0F, 32'h0, 0, 0, 6'h2F, a1);
        issue(32'hF0, 0, 2, 32'h0, 32'h0F0F0F0F, 0, 1, 6'h3F, a1);
        idle(3);
        bad_on = -1;
        issue(32'hF1, 0, 0, 32'h0, 32'h0000000F, 0, 0, -1, a1);
        idle(4);

        // reset during a data phase with a response pending
        rsp_ready = 0;
        issue(32'h20, 1, 2, 32'h55AA55AA, 32'h0, 0, 0, -1, a1);
        issue(32'h20, 0, 2, 32'h0, 32'h55AA55AA, 0, 0, -1, a1);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_htrans", m_htrans, 2'b00);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mid_req_ready", req_ready, 1'b1);
        chk("rst_mid_hwdata", m_hwdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; rsp_ready = 1;
        @(negedge clk); chk("rst_rsp_lost", rsp_valid, 1'b0);
        @(posedge clk); #1;
        issue(32'h20, 0, 2, 32'h0, 32'h55AA55AA, 0, 0, -1, a1);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) idle(1);
        chk("drain", exp_q.size(), 0);
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
